// File: rtl/periph_rx_scheduler_pkg.sv
// Shared constants and types for the peripheral-to-USB scheduling path.
// Combinational only: no latency, no backpressure.
// Imported by the scheduler and its bench.
package lycan_globals;

    localparam int num_peripherals  = 8;
    localparam int usb_packet_width = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_t;

endpackage

// File: rtl/periph_rx_scheduler_rr_pick.sv
// Masked round-robin first-set finder: first requester after 'last', wrapping.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request bit is set.
module rr_pick #(
    parameter int N  = 8,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [LW-1:0] idx,
    output logic          found
);

    // N is a power of two, so the LW-bit add wraps naturally; offset N lands back on 'last'.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            logic [LW-1:0] cand;
            cand = last + LW'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/periph_rx_scheduler.sv
// Round-robin, burst-bounded arbiter sharing the output FIFO write port among peripheral RX FIFOs.
// Latency: request seen in IDLE at N -> rx_read at N+1 -> registered out_wr/out_data at N+2.
// Backpressure: pops are gated by out_almost_full; the one free slot absorbs the registered write.
module periph_rx_scheduler
    import lycan_globals::*;
#(
    parameter int NUM_PERIPH = num_peripherals,
    parameter int WIDTH      = usb_packet_width,
    parameter int MAX_BURST  = 16,
    parameter int GW         = $clog2(NUM_PERIPH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PERIPH-1:0]       rx_empty,
    input  logic [NUM_PERIPH-1:0]       rx_almost_full,
    input  logic [NUM_PERIPH*WIDTH-1:0] rx_data,
    output logic [NUM_PERIPH-1:0]       rx_read,
    input  logic                        out_almost_full,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_wr,
    output logic [GW-1:0]               grant,
    output logic                        grant_valid
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    sched_state_t          state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         last_q, last_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pop;

    logic [NUM_PERIPH-1:0] req, urg;
    logic [GW-1:0]         urg_idx, req_idx, winner;
    logic                  urg_found, req_found;

    assign req = ~rx_empty;
    assign urg = req & rx_almost_full;

    rr_pick #(.N(NUM_PERIPH), .LW(GW)) u_pick_urg (
        .req   (urg),
        .last  (last_q),
        .idx   (urg_idx),
        .found (urg_found)
    );

    rr_pick #(.N(NUM_PERIPH), .LW(GW)) u_pick_req (
        .req   (req),
        .last  (last_q),
        .idx   (req_idx),
        .found (req_found)
    );

    // Almost-full requesters form a strictly higher urgency class.
    assign winner = urg_found ? urg_idx : req_idx;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (urg_found || req_found) begin
                    grant_d = winner;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (rx_empty[grant_q]) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end else if (!out_almost_full) begin
                    pop   = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Suppressed during reset so no word leaves a source FIFO that is being flushed.
    always_comb begin
        rx_read = '0;
        if (pop && !rst) begin
            rx_read[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= GW'(NUM_PERIPH - 1);
            cnt_q    <= '0;
            out_wr   <= 1'b0;
            out_data <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            out_wr  <= pop;
            if (pop) begin
                out_data <= rx_data[grant_q*WIDTH +: WIDTH];
            end
        end
    end

    assign grant       = grant_q;
    assign grant_valid = (state_q == BURST);

endmodule
